overdrive_shaper: RTL and testbench

// - Pipelined, parametrised waveshaper; next generation of the combinational overdrive clamp.
// - Sits in the effects chain between input gain staging and tone/volume; one mono sample stream.
// - Adds a runtime-selectable curve (bypass / hard clip / cubic soft clip), a pre-gain multiply and a valid/ready handshake with backpressure.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/overdrive_shaper_if.sv | 26 ++
 rtl/fx_mul_sat.sv | 49 ++++
 rtl/overdrive_shaper.sv | 125 ++++++++++++
 tb/tb_overdrive_shaper.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the effects chain: shaper curve selection,
// default fixed-point format and the fixed-point unity helper.
package dsp_pkg;

   localparam int WIDTH_DEFAULT  = 24;
   localparam int FRAC_DEFAULT   = 12;
   localparam int SHAPER_LATENCY = 4;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_HARD   = 2'd1,
      MODE_SOFT   = 2'd2,
      MODE_RSVD   = 2'd3
   } shaper_mode_t;

   // Unity (1.0) for a fixed-point format with 'frac' fractional bits.
   function automatic int one(input int frac);
      return 1 << frac;
   endfunction

endpackage

// File: rtl/overdrive_shaper_if.sv
// Sample-stream bus for the overdrive shaper: upstream valid/ready with
// per-sample gain and mode, downstream valid/ready with the shaped sample.
interface overdrive_shaper_if import dsp_pkg::*; #(
   parameter int WIDTH = WIDTH_DEFAULT
) ();

   logic                    i_valid;
   logic                    o_ready;
   logic signed [WIDTH-1:0] i_sample;
   logic signed [WIDTH-1:0] i_gain;
   shaper_mode_t            i_mode;
   logic                    o_valid;
   logic                    i_ready;
   logic signed [WIDTH-1:0] o_sample;

   modport master (
      output i_valid, i_sample, i_gain, i_mode, i_ready,
      input  o_ready, o_valid, o_sample
   );

   modport slave (
      input  i_valid, i_sample, i_gain, i_mode, i_ready,
      output o_ready, o_valid, o_sample
   );

endinterface

// File: rtl/fx_mul_sat.sv
// Registered signed fixed-point multiply: full-width product, arithmetic
// (floor) shift by FRAC, then optional saturation back to WIDTH bits.
module fx_mul_sat #(
   parameter int WIDTH = 24,
   parameter int FRAC  = 12,
   parameter bit SAT   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p
);

   localparam int PW = 2 * WIDTH;
   localparam logic signed [PW-1:0] MAX_V = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_V = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [PW-1:0]    a_ext;
   logic signed [PW-1:0]    b_ext;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    shifted;
   logic signed [WIDTH-1:0] result;

   // Full-precision product, floor shift and clamp into the output range.
   always_comb begin
      a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
      b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
      prod    = a_ext * b_ext;
      shifted = prod >>> FRAC;
      result  = shifted[WIDTH-1:0];
      if (SAT && (shifted > MAX_V)) begin
         result = MAX_V[WIDTH-1:0];
      end else if (SAT && (shifted < MIN_V)) begin
         result = MIN_V[WIDTH-1:0];
      end
   end

   // Product register; holds whenever the owning pipeline is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= '0;
      end else if (en) begin
         p <= result;
      end
   end

endmodule

// File: rtl/overdrive_shaper.sv
// Four-stage overdrive waveshaper: pre-gain, square, cube, then curve select
// (bypass / hard clip / cubic soft clip). Gain and mode ride along with each
// sample, and the whole pipeline stalls together under downstream backpressure.
module overdrive_shaper import dsp_pkg::*; #(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int FRAC  = FRAC_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   overdrive_shaper_if.slave bus
);

   localparam logic signed [WIDTH-1:0] ONE_V     = WIDTH'(one(FRAC));
   localparam logic signed [WIDTH-1:0] NEG_ONE_V = -ONE_V;

   logic                        advance;
   logic [SHAPER_LATENCY-1:0]   stage_valid;
   logic signed [WIDTH-1:0]     x_s1;
   logic signed [WIDTH-1:0]     x_s2;
   logic signed [WIDTH-1:0]     x_s3;
   logic signed [WIDTH-1:0]     x2_s2;
   logic signed [WIDTH-1:0]     x3_s3;
   logic signed [WIDTH-1:0]     shaped;
   logic signed [WIDTH+2:0]     x_ext;
   logic signed [WIDTH+2:0]     x3_ext;
   logic signed [WIDTH+2:0]     soft_sum;
   logic signed [WIDTH+2:0]     soft_half;
   shaper_mode_t                mode_s1;
   shaper_mode_t                mode_s2;
   shaper_mode_t                mode_s3;

   assign advance     = !bus.o_valid || bus.i_ready;
   assign bus.o_ready = advance;
   assign bus.o_valid = stage_valid[SHAPER_LATENCY-1];

   // Stage 1: pre-gain with saturation, so hot inputs pin at full scale.
   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(1'b1)) u_gain (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (advance),
      .a     (bus.i_sample),
      .b     (bus.i_gain),
      .p     (x_s1)
   );

   // Stage 2: x squared; only meaningful for |x| < One, saturated otherwise.
   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(1'b1)) u_square (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (advance),
      .a     (x_s1),
      .b     (x_s1),
      .p     (x2_s2)
   );

   // Stage 3: x cubed from the registered square and the carried x.
   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(1'b1)) u_cube (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (advance),
      .a     (x2_s2),
      .b     (x_s2),
      .p     (x3_s3)
   );

   // Valid bits march with the data; bubbles are kept, never collapsed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stage_valid <= '0;
      end else if (advance) begin
         stage_valid <= {stage_valid[SHAPER_LATENCY-2:0], bus.i_valid};
      end
   end

   // Carry x and the captured mode alongside the multiplier stages, and
   // register the shaped result as the output sample.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_s1      <= MODE_BYPASS;
         mode_s2      <= MODE_BYPASS;
         mode_s3      <= MODE_BYPASS;
         x_s2         <= '0;
         x_s3         <= '0;
         bus.o_sample <= '0;
      end else if (advance) begin
         mode_s1      <= bus.i_mode;
         mode_s2      <= mode_s1;
         mode_s3      <= mode_s2;
         x_s2         <= x_s1;
         x_s3         <= x_s2;
         bus.o_sample <= shaped;
      end
   end

   // Curve select; soft clip is (3x - x^3)/2 inside +-One and flat outside.
   always_comb begin
      shaped    = x_s3;
      x_ext     = {{3{x_s3[WIDTH-1]}}, x_s3};
      x3_ext    = {{3{x3_s3[WIDTH-1]}}, x3_s3};
      soft_sum  = (x_ext <<< 1) + x_ext - x3_ext;
      soft_half = soft_sum >>> 1;
      case (mode_s3)
         MODE_HARD: begin
            if (x_s3 > ONE_V) begin
               shaped = ONE_V;
            end else if (x_s3 < NEG_ONE_V) begin
               shaped = NEG_ONE_V;
            end
         end
         MODE_SOFT: begin
            if (x_s3 >= ONE_V) begin
               shaped = ONE_V;
            end else if (x_s3 <= NEG_ONE_V) begin
               shaped = NEG_ONE_V;
            end else begin
               shaped = WIDTH'(soft_half);
            end
         end
         default: begin
            shaped = x_s3;
         end
      endcase
   end

endmodule

// File: tb/tb_overdrive_shaper.sv
// Self-checking bench for overdrive_shaper: arithmetic reference model with a
// scoreboard, directed literal cases, backpressure, mode switching and reset.
module tb_overdrive_shaper import dsp_pkg::*;;

   localparam int     W      = 24;
   localparam longint ONE_Q  = 4096;
   localparam longint MAX_Q  = 8388607;
   localparam longint MIN_Q  = -8388608;

   logic clk;
   logic rst_n;

   int vectors;
   int miscompares;

   longint exp_q[$];
   bit     held_valid;
   longint held_sample;

   overdrive_shaper_if #(.WIDTH(W)) bus ();

   overdrive_shaper dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the shaping rules written as plain integer arithmetic.
   function automatic longint sat_w(input longint v);
      if (v > MAX_Q) return MAX_Q;
      if (v < MIN_Q) return MIN_Q;
      return v;
   endfunction

   function automatic longint model_shape(input longint s, input longint g, input shaper_mode_t m);
      longint x;
      longint x2;
      longint x3;
      x = sat_w((s * g) >>> 12);
      case (m)
         MODE_HARD: begin
            if (x > ONE_Q) return ONE_Q;
            if (x < -ONE_Q) return -ONE_Q;
            return x;
         end
         MODE_SOFT: begin
            if (x >= ONE_Q) return ONE_Q;
            if (x <= -ONE_Q) return -ONE_Q;
            x2 = (x * x) >>> 12;
            x3 = (x2 * x) >>> 12;
            return (3 * x - x3) >>> 1;
         end
         default: return x;
      endcase
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input longint s, input longint g, input shaper_mode_t m, input logic v);
      bus.i_sample = W'(s);
      bus.i_gain   = W'(g);
      bus.i_mode   = m;
      bus.i_valid  = v;
   endtask

   // Compare process: mirrors each transfer into/out of the scoreboard and
   // checks output stability while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         held_valid = 1'b0;
      end else begin
         checkOutput("o_ready", longint'(bus.o_ready), longint'(!bus.o_valid || bus.i_ready));
         if (held_valid) begin
            checkOutput("stall_valid", longint'(bus.o_valid), 1);
            checkOutput("stall_sample", longint'(bus.o_sample), held_sample);
         end
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_output", 1, 0);
            end else begin
               checkOutput("scoreboard", longint'(bus.o_sample), exp_q.pop_front());
            end
         end
         held_valid  = bus.o_valid && !bus.i_ready;
         held_sample = longint'(bus.o_sample);
         if (bus.i_valid && bus.o_ready) begin
            exp_q.push_back(model_shape(longint'(bus.i_sample), longint'(bus.i_gain), bus.i_mode));
         end
      end
   end

   task automatic drain();
      int guard;
      guard = 0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.o_valid) && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("drain_empty", longint'(exp_q.size()), 0);
   endtask

   task automatic run_single(input string name, input longint s, input longint g,
                             input shaper_mode_t m, input longint expected);
      int cycles;
      bus.i_ready = 1'b1;
      applyStimulus(s, g, m, 1'b1);
      @(posedge clk); #1;
      applyStimulus(0, 0, MODE_BYPASS, 1'b0);
      cycles = 1;
      while (!bus.o_valid && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput({name, "_latency"}, longint'(cycles), 4);
      checkOutput(name, longint'(bus.o_sample), expected);
      @(posedge clk); #1;
   endtask

   task automatic run_stream(input int n, input bit use_ramp);
      int idx;
      int guard;
      longint cur_s;
      longint cur_g;
      shaper_mode_t cur_m;
      bit need;
      idx   = 0;
      guard = 0;
      need  = 1'b1;
      cur_s = 0;
      cur_g = 0;
      cur_m = MODE_BYPASS;
      while (idx < n && guard < n * 20) begin
         if (need) begin
            if (use_ramp) begin
               cur_s = longint'(idx) * 150 - 4800;
            end else if ($urandom_range(0, 3) == 0) begin
               cur_s = longint'($signed(W'($urandom)));
            end else begin
               cur_s = longint'($urandom_range(0, 16383)) - 8192;
            end
            if ($urandom_range(0, 3) == 0) begin
               cur_g = longint'($signed(W'($urandom)));
            end else begin
               cur_g = longint'($urandom_range(0, 12288));
            end
            cur_m = shaper_mode_t'($urandom_range(0, 3));
            need  = 1'b0;
         end
         bus.i_ready = ($urandom_range(0, 3) != 0);
         applyStimulus(cur_s, cur_g, cur_m, ($urandom_range(0, 5) != 0));
         #2;
         if (bus.i_valid && bus.o_ready) begin
            idx++;
            need = 1'b1;
         end
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("stream_progress", longint'(idx), longint'(n));
      drain();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint soft_x[4];
      longint hard_x[4];
      vectors     = 0;
      miscompares = 0;
      held_valid  = 1'b0;
      held_sample = 0;
      rst_n       = 1'b0;
      bus.i_ready = 1'b1;
      applyStimulus(0, 0, MODE_BYPASS, 1'b0);

      #2;
      checkOutput("reset_o_valid", longint'(bus.o_valid), 0);
      checkOutput("reset_o_sample", longint'(bus.o_sample), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("reset_o_ready", longint'(bus.o_ready), 1);
      @(posedge clk); #1;

      $display("[TB] directed curve cases");
      run_single("soft_half",     2048,  4096, MODE_SOFT,   2816);
      run_single("soft_neg_half", -2048, 4096, MODE_SOFT,   -2816);
      run_single("soft_over",     5000,  4096, MODE_SOFT,   4096);
      run_single("soft_one",      4096,  4096, MODE_SOFT,   4096);
      run_single("soft_neg_one",  -4096, 4096, MODE_SOFT,   -4096);
      run_single("hard_clip",     3000,  8192, MODE_HARD,   4096);
      run_single("hard_linear",   -1000, 8192, MODE_HARD,   -2000);
      run_single("bypass_gain",   3000,  8192, MODE_BYPASS, 6000);
      run_single("gain_sat_pos",  MAX_Q, MAX_Q, MODE_BYPASS, MAX_Q);
      run_single("gain_sat_neg",  MIN_Q, MAX_Q, MODE_BYPASS, MIN_Q);
      run_single("hard_min",      MIN_Q, 4096, MODE_HARD,   -4096);
      run_single("soft_min",      MIN_Q, 4096, MODE_SOFT,   -4096);
      run_single("zero_gain",     12345, 0,    MODE_SOFT,   0);
      run_single("reserved_mode", 5000,  4096, MODE_RSVD,   5000);

      $display("[TB] mode change in flight");
      soft_x = '{2048, -2048, 5000, 1000};
      hard_x = '{3000, 6000, -6000, -100};
      bus.i_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(soft_x[i], 4096, MODE_SOFT, 1'b1);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(hard_x[i], 4096, MODE_HARD, 1'b1);
         @(posedge clk); #1;
      end
      drain();

      $display("[TB] ramp with backpressure");
      run_stream(64, 1'b1);

      $display("[TB] randomized stream");
      run_stream(300, 1'b0);

      $display("[TB] reset with samples in flight");
      bus.i_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1000 * (i + 1), 4096, MODE_SOFT, 1'b1);
         @(posedge clk); #1;
      end
      checkOutput("inflight_valid", longint'(bus.o_valid), 1);
      applyStimulus(0, 0, MODE_BYPASS, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_async_valid", longint'(bus.o_valid), 0);
      checkOutput("reset_async_sample", longint'(bus.o_sample), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checkOutput("no_stale", longint'(bus.o_valid), 0);
      end
      run_single("post_reset", 2048, 4096, MODE_SOFT, 2816);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
